// File: rtl/mux_arb_n_pkg.sv
// mux_pkg: shared constants and index helpers for the mux_arb_n block.
//   MUX_MODE_SEL / MUX_MODE_RR : encodings of the MODE parameter.
//   wrap_idx(v, n)             : folds v in [0, 2n) back into [0, n).
//   next_idx(idx, n)           : modulo-n increment, wraps n-1 -> 0 explicitly
//                                so non-power-of-two channel counts never
//                                produce an out-of-range index.
package mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    function automatic int unsigned wrap_idx(input int unsigned v, input int unsigned n);
        return (v >= n) ? (v - n) : v;
    endfunction

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return wrap_idx(idx + 1, n);
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: producer/consumer bus of the N-channel arbitrating mux.
//   in_data   N*W  packed channel data, channel i at [i*W +: W]
//   in_valid  N    per-channel valid
//   in_ready  N    per-channel ready, one-hot or zero
//   sel       SW   external channel select (MODE=0 only)
//   out_data  W    registered selected word
//   out_ch    SW   channel that produced out_data
//   out_valid 1    output register holds a word
//   out_ready 1    consumer takes out_data this cycle
//   dbg_ptr   SW   round-robin pointer, exposed for observation
// Handshake: a word moves on any rising edge where valid and ready are both
// high on the same side; valid must not depend on ready, ready may depend on
// valid, and a producer keeps data stable while valid is high and ready low.
// slave is the mux side, master is the environment side.
interface mux_arb_n_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  dbg_ptr;

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid, dbg_ptr
    );

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid, dbg_ptr
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   valid   N   request vector
//   ptr     SW  highest-priority channel this cycle (must be < N)
//   gnt_vld 1   some channel is requesting
//   gnt_idx SW  first requesting channel at or after ptr, modulo N
import mux_pkg::*;

module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    logic [SW-1:0] cand;

    // Walk ptr, ptr+1, ... with explicit modulo-N wrap; the first hit wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = SW'(wrap_idx(int'(ptr) + off, N));
            if (!gnt_vld && valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, W-bit multiplexer with valid/ready per channel and a
// registered output stage.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_arb_n_if.slave (channel inputs, select, registered output)
// MODE=0 grants the channel named by sel if it is valid; MODE=1 grants in
// round-robin order starting at the pointer, which advances past each winner.
import mux_pkg::*;

module mux_arb_n #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MUX_MODE_SEL
) (
    input logic         clk,
    input logic         rst_n,
    mux_arb_n_if.slave  bus
);

    localparam int SW = $clog2(N);

    logic [W-1:0]  ch_data [N];
    logic          load_en;
    logic          sel_vld;
    logic          rr_vld;
    logic [SW-1:0] rr_idx;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic [N-1:0]  ready;
    logic          xfer;

    logic [W-1:0]  data_q;
    logic [SW-1:0] ch_q;
    logic          valid_q;
    logic [SW-1:0] ptr_q;

    for (genvar i = 0; i < N; i++) begin : g_split
        assign ch_data[i] = bus.in_data[i*W +: W];
    end

    // The output register can take a word when empty or being drained now.
    assign load_en = !valid_q || bus.out_ready;

    // sel beyond the last channel never grants (matters when N < 2**SW).
    assign sel_vld = (int'(bus.sel) < N) && bus.in_valid[bus.sel];

    if (MODE == MUX_MODE_RR) begin : g_rr
        rr_pick #(.N(N), .SW(SW)) u_pick (
            .valid   (bus.in_valid),
            .ptr     (ptr_q),
            .gnt_vld (rr_vld),
            .gnt_idx (rr_idx)
        );
    end else begin : g_no_rr
        assign rr_vld = 1'b0;
        assign rr_idx = '0;
    end

    assign gnt_vld = (MODE == MUX_MODE_RR) ? rr_vld : sel_vld;
    assign gnt_idx = (MODE == MUX_MODE_RR) ? rr_idx : bus.sel;

    always_comb begin
        ready = '0;
        if (rst_n && load_en && gnt_vld) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |(bus.in_valid & ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (xfer) begin
            data_q  <= ch_data[gnt_idx];
            ch_q    <= gnt_idx;
            valid_q <= 1'b1;
            if (MODE == MUX_MODE_RR) begin
                ptr_q <= SW'(next_idx(int'(gnt_idx), N));
            end
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.dbg_ptr   = ptr_q;

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshake and a registered output stage.
- Two selection modes: external select (the successor of the fixed 2:1/4:1 select muxes) and round-robin arbitration.
- Sits between multiple producers and a single consumer in the datapath.
- Adds throughput of one transfer per cycle, back-pressure and fairness.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width per channel in bits.
- MODE, 0, selection mode: 0 = external select via sel; 1 = round-robin among valid channels.
- SW, $clog2(N), derived width of channel index; not user-overridden.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit set in any cycle.
- sel  in  SW  channel select, used only when MODE=0.
- out_data  out  W  registered selected data.
- out_ch  out  SW  index of the channel that produced out_data.
- out_valid  out  1  output register holds a valid word.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, out_data=0, out_ch=0, round-robin pointer=0.
  - in_ready is combinational and is 0 while rst_n=0.
  - Reset mid-operation discards any held word; no partial transfer survives.
- load_en = !out_valid || out_ready. The output register may accept a new word only when load_en=1.
- Grant, MODE=0:
  - grant = sel when sel < N and in_valid[sel]=1; otherwise no grant.
  - sel >= N never grants.
- Grant, MODE=1:
  - Take the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1, modulo N.
  - No grant when all in_valid are 0.
- in_ready[g] = load_en && grant exists && rst_n. All other in_ready bits are 0.
- Transfer on channel g: in_valid[g] && in_ready[g] at a clock edge. On that edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - in MODE=1 only, ptr <= (g+1) mod N. The pointer wraps from N-1 to 0.
- Consumer takes the word (out_valid && out_ready) with no new transfer on the same edge: out_valid <= 0. out_data and out_ch hold their last value.
- Simultaneous consume and transfer on one edge: the new word replaces the old, out_valid stays 1. Sustained throughput is 1 word/cycle.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid hold stable, all in_ready=0, ptr holds.
- ptr changes only on a transfer. An idle cycle or a no-grant cycle leaves ptr unchanged.
- Latency: 1 cycle from the transfer edge to out_valid/out_data visible.
- No data-dependent arithmetic. Index arithmetic is SW bits wide. For N not a power of two, the modulo-N wrap is explicit, not SW-bit overflow.
- Fairness (MODE=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0 with no channel skipped.

Decomposition:
- Shared package mux_pkg holds:
  - localparam mode encodings MUX_MODE_SEL=0, MUX_MODE_RR=1.
  - function next_idx(idx, n) for the modulo-N increment.
- One natural sub-module, rr_pick: combinational rotating priority picker.
  - Inputs: valid[N], ptr[SW].
  - Outputs: gnt_vld, gnt_idx[SW].
  - Instantiated only when MODE=1 (generate).
- The output register, load_en logic and ptr register live in mux_arb_n.

Test Plan:
- MODE=0, N=4, W=8, out_ready=1:
  - sel=2, in_valid=4'b0100, in_data[23:16]=8'hA5 -> next cycle out_valid=1, out_data=8'hA5, out_ch=2, in_ready=4'b0100 during the request.
  - sel=3 with in_valid[3]=0 -> in_ready=0, out_valid drops to 0 next cycle.
- MODE=1, N=4, in_valid=4'b1111 held, out_ready=1, channel i data = 8'h10+i:
  - out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
  - out_data 8'h10,8'h11,8'h12,8'h13,8'h10,...
  - out_valid continuously 1 after the first cycle.
- MODE=1, in_valid=4'b1010, ptr=0 after reset -> grants 1,3,1,3; ptr wraps 3->0 and skips the invalid channels.
- Back-pressure: load one word 8'h3C, then hold out_ready=0 for 5 cycles with all in_valid=1:
  - out_data stays 8'h3C, in_ready=0 throughout, ptr unchanged.
  - On out_ready=1 the next channel in round-robin order transfers on that same edge.
- Reset mid-stream: rst_n=0 for one edge while out_valid=1 and out_ready=0:
  - next cycle out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset.
  - The first grant after reset (MODE=1, all valid) is channel 0.
- Non-power-of-two: N=3, MODE=1, all valid -> out_ch sequence 0,1,2,0; index 3 never appears.
